// File: rtl/barrel_shift_left_pipe_if.sv
// Handshake bundle for barrel_shift_left_pipe.
//   master : operand producer plus result consumer (drives in_*, out_ready)
//   slave  : the shifter pipeline (drives in_ready, out_valid, out_data, busy)
// Signals:
//   in_valid/in_ready   operand handshake
//   in_data, in_k       operand and shift amount (0..WIDTH-1)
//   in_rot              0 = logical left (zero fill), 1 = rotate left
//   out_valid/out_ready result handshake
//   out_data            shifted result
//   busy                any stage holds a transaction
interface barrel_shift_left_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_k;
    logic             in_rot;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_k, in_rot, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_k, in_rot, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/barrel_shift_left_pipe.sv
// Pipelined left barrel shifter with valid/ready handshakes on both sides.
// Stage i conditionally shifts by 2^i (controlled by k[i]), so a WIDTH-bit operand
// needs SHW = log2(WIDTH) stages and emerges SHW edges after acceptance.
// Each stage has its own ready, so bubbles collapse under output backpressure.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; empties and zeroes every stage
//   bus    barrel_shift_left_pipe_if slave modport (operand in, result out, busy)
module barrel_shift_left_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3   // must be log2(WIDTH)
) (
    input logic                     clk,
    input logic                     rst_n,
    barrel_shift_left_pipe_if.slave bus
);

    logic [SHW-1:0]            valid_q, valid_d;
    logic [SHW-1:0][WIDTH-1:0] data_q,  data_d;
    logic [SHW-1:0][SHW-1:0]   k_q,     k_d;
    logic [SHW-1:0]            rot_q,   rot_d;
    logic [SHW-1:0]            ready;

    // What each stage would load: the input port for stage 0, the previous stage otherwise.
    logic [SHW-1:0]            up_valid;
    logic [SHW-1:0][WIDTH-1:0] up_data;
    logic [SHW-1:0][SHW-1:0]   up_k;
    logic [SHW-1:0]            up_rot;

    // The last stage's k/rot have no consumer; they are kept for uniformity.
    logic unused_tail;
    assign unused_tail = ^{k_q[SHW-1], rot_q[SHW-1]};

    // Upper half of {x, x} << s is (x << s) | (x >> (WIDTH - s)), i.e. the rotate.
    function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] x,
                                                    input int unsigned      s,
                                                    input logic             rot);
        logic [2*WIDTH-1:0] dbl;
        dbl = {x, x} << s;
        return rot ? dbl[2*WIDTH-1:WIDTH] : (x << s);
    endfunction

    // Ready ripples back from the consumer; a stage is free if empty or if it
    // will hand its content on this edge.
    always_comb begin
        ready          = '0;
        ready[SHW-1]   = !valid_q[SHW-1] || bus.out_ready;
        for (int i = int'(SHW) - 2; i >= 0; i--) begin
            ready[i] = !valid_q[i] || ready[i+1];
        end
    end

    always_comb begin
        up_valid[0] = bus.in_valid;
        up_data[0]  = bus.in_data;
        up_k[0]     = bus.in_k;
        up_rot[0]   = bus.in_rot;
        for (int i = 1; i < int'(SHW); i++) begin
            up_valid[i] = valid_q[i-1];
            up_data[i]  = data_q[i-1];
            up_k[i]     = k_q[i-1];
            up_rot[i]   = rot_q[i-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        k_d     = k_q;
        rot_d   = rot_q;
        for (int i = 0; i < int'(SHW); i++) begin
            if (ready[i]) begin
                valid_d[i] = up_valid[i];
                // Payload is only captured from a valid upstream; bubbles leave it alone.
                if (up_valid[i]) begin
                    data_d[i] = up_k[i][i] ? shift_left(up_data[i], 32'd1 << i, up_rot[i])
                                           : up_data[i];
                    k_d[i]    = up_k[i];
                    rot_d[i]  = up_rot[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            k_q     <= '0;
            rot_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            k_q     <= k_d;
            rot_q   <= rot_d;
        end
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = valid_q[SHW-1];
    assign bus.out_data  = data_q[SHW-1];
    assign bus.busy      = |valid_q;

endmodule

// File: tb/tb_barrel_shift_left_pipe.sv
// Self-checking bench for barrel_shift_left_pipe: directed steps from the test plan
// followed by a randomized stream, all checked against an arithmetic reference model
// and a scoreboard of in-flight operands.
module tb_barrel_shift_left_pipe;
    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    typedef struct {
        logic [7:0] data;
        int         t;
    } exp_t;

    logic clk;
    logic rst_n;

    barrel_shift_left_pipe_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    barrel_shift_left_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         tick_n  = 0;
    int         n_acc   = 0;
    int         ph_drains, ph_first, ph_last;
    logic       lat_check = 1'b0;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data;
    logic [7:0] last_out;
    logic [7:0] outs[$];
    exp_t       q[$];

    // Shift rule in plain arithmetic: multiply by 2^k, wrap the overflow back if rotating.
    function automatic logic [7:0] ref_shl(input logic [7:0] x, input int k, input logic rot);
        int v, r;
        v = int'(x);
        r = v * (2 ** k);
        if (rot) r = r + v / (2 ** (WIDTH - k));
        return 8'(r % (2 ** WIDTH));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_phase();
        ph_drains = 0;
        ph_first  = 0;
        ph_last   = 0;
        outs.delete();
    endtask

    // One clock: sample and check at the falling edge, update the scoreboard, then
    // return just after the rising edge so the caller can drive new inputs.
    task automatic tick();
        logic acc, drn;
        exp_t e;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        drn = bus.out_valid && bus.out_ready;
        chk("in_ready", 32'(bus.in_ready), 32'((q.size() < SHW) || bus.out_ready));
        chk("busy", 32'(bus.busy), 32'(q.size() != 0));
        if (q.size() == 0) chk("stale_out_valid", 32'(bus.out_valid), 32'(0));
        if (hold_pend) begin
            chk("hold_valid", 32'(bus.out_valid), 32'(1));
            chk("hold_data", 32'(bus.out_data), 32'(hold_data));
        end
        hold_pend = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        if (drn && q.size() != 0) begin
            e = q.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(e.data));
            if (lat_check) chk("latency", 32'(tick_n - e.t), 32'(SHW));
            last_out = bus.out_data;
            outs.push_back(bus.out_data);
            if (ph_drains == 0) ph_first = tick_n;
            ph_last = tick_n;
            ph_drains++;
        end
        if (acc) begin
            q.push_back('{data: ref_shl(bus.in_data, int'(bus.in_k), bus.in_rot), t: tick_n});
            n_acc++;
        end
        @(posedge clk);
        #1;
        tick_n++;
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] k, input logic r);
        int guard;
        int a0;
        guard = 0;
        a0    = n_acc;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_k     = k;
        bus.in_rot   = r;
        while (n_acc == a0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("send_accept", 32'(n_acc - a0), 32'(1));
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_k     = 3'($urandom);
        bus.in_rot   = 1'($urandom);
    endtask

    task automatic drain_all();
        int guard;
        guard = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (q.size() != 0 && guard < 30) begin
            tick();
            guard++;
        end
        chk("drain_empty", 32'(q.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d_tab[7];
        logic [2:0] k_tab[7];
        logic       r_tab[7];
        logic [7:0] x_tab[7];
        logic [7:0] one_hot;
        int         a0;

        d_tab = '{8'h81, 8'hA5, 8'hFF, 8'h81, 8'hB4, 8'h81, 8'hA5};
        k_tab = '{3'd7,  3'd0,  3'd4,  3'd1,  3'd4,  3'd7,  3'd0};
        r_tab = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1};
        x_tab = '{8'h80, 8'hA5, 8'hF0, 8'h03, 8'h4B, 8'hC0, 8'hA5};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_k      = '0;
        bus.in_rot    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state, observed before any clock edge.
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_data", 32'(bus.out_data), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single logical op and its exact latency.
        lat_check = 1'b1;
        clear_phase();
        send(8'h01, 3'd3, 1'b0);
        chk("lat_after_e0", 32'(bus.out_valid), 32'(0));
        tick();
        chk("lat_after_e1", 32'(bus.out_valid), 32'(0));
        tick();
        chk("lat_after_e2", 32'(bus.out_valid), 32'(1));
        drain_all();
        chk("op_01_k3_log", 32'(last_out), 32'(8'h08));

        // Boundary and rotate cases.
        for (int i = 0; i < 7; i++) begin
            send(d_tab[i], k_tab[i], r_tab[i]);
            drain_all();
            chk($sformatf("plan_%0h_k%0d_r%0d", d_tab[i], k_tab[i], r_tab[i]),
                32'(last_out), 32'(x_tab[i]));
        end

        // Back-to-back stream of eight operands.
        clear_phase();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h01;
            bus.in_k     = 3'(k);
            bus.in_rot   = 1'b0;
            a0 = n_acc;
            tick();
            chk("stream_accept", 32'(n_acc - a0), 32'(1));
        end
        drain_all();
        chk("stream_count", 32'(ph_drains), 32'(8));
        chk("stream_span", 32'(ph_last - ph_first), 32'(7));
        for (int i = 0; i < 8 && i < outs.size(); i++) begin
            one_hot = 8'h01 << i;
            chk("stream_value", 32'(outs[i]), 32'(one_hot));
        end

        // Backpressure: fill, stall, then drain while accepting on the full pipe.
        lat_check = 1'b0;
        clear_phase();
        bus.out_ready = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            bus.in_k     = 3'($urandom);
            bus.in_rot   = 1'($urandom);
            tick();
        end
        chk("bp_accepted", 32'(n_acc - a0), 32'(3));
        chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
        chk("bp_out_valid", 32'(bus.out_valid), 32'(1));
        bus.out_ready = 1'b1;
        bus.in_data   = 8'h5A;
        bus.in_k      = 3'd3;
        bus.in_rot    = 1'b1;
        #1;
        chk("bp_ready_follows", 32'(bus.in_ready), 32'(1));
        a0 = n_acc;
        tick();
        chk("bp_accept_on_drain", 32'(n_acc - a0), 32'(1));
        chk("bp_first_drain", 32'(ph_drains), 32'(1));
        drain_all();
        chk("bp_drain_count", 32'(ph_drains), 32'(4));
        chk("bp_drain_span", 32'(ph_last - ph_first), 32'(3));

        // Asynchronous reset with two operands in flight.
        bus.out_ready = 1'b0;
        send(8'h11, 3'd1, 1'b0);
        send(8'h22, 3'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("arst_busy", 32'(bus.busy), 32'(0));
        chk("arst_out_data", 32'(bus.out_data), 32'(0));
        chk("arst_in_ready", 32'(bus.in_ready), 32'(1));
        q.delete();
        hold_pend    = 1'b0;
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lat_check     = 1'b1;
        bus.out_ready = 1'b1;
        send(8'h03, 3'd2, 1'b0);
        drain_all();
        chk("post_rst_op", 32'(last_out), 32'(8'h0C));
        for (int i = 0; i < 5; i++) tick();

        // Randomized traffic with random backpressure.
        lat_check = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 8'($urandom);
            bus.in_k      = 3'($urandom);
            bus.in_rot    = 1'($urandom);
            bus.out_ready = ($urandom_range(3) != 0);
            tick();
        end
        drain_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/barrel_shift_left_pipe.md
Name: barrel_shift_left_pipe

Overview:
- Pipelined, valid/ready-handshaked left barrel shifter. It is the companion to the team's combinational 8-bit right barrel shifter `barrel_shift`.
- Shifts a WIDTH-bit operand left by k positions. Mode selects zero-fill or rotate.
- Uses one register stage per shift-amount bit: stage i shifts by 2^i.
- Sits between an operand producer and a consumer in the datapath, with full backpressure and bubble collapsing.

Parameters:
- WIDTH, 8, operand and result width in bits.
- SHW, 3, shift-amount width. Must equal log2(WIDTH). It is also the number of pipeline stages.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input transaction present.
- in_ready  output  1  stage 0 can accept this cycle.
- in_data  input  WIDTH  operand A.
- in_k  input  SHW  shift amount, 0..WIDTH-1.
- in_rot  input  1  0 = logical left, zero-fill LSBs; 1 = rotate left, MSBs wrap into LSBs.
- out_valid  output  1  result present (stage SHW-1 valid).
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- busy  output  1  OR of all stage valid bits.

Behaviour:
- Reset: clk and one reset only; reset is asynchronous, active-low (rst_n).
  - While rst_n=0, all stage valid bits are cleared and all stage data/k/rot registers are zeroed immediately, independent of clk.
  - Outputs in reset: out_valid=0, out_data=0, busy=0, in_ready=1.
- Pipeline storage: stages 0..SHW-1. Each stage holds valid_i, data_i (WIDTH), k_i (SHW) and rot_i.
- Stage operations:
  - Stage 0 loads in_data shifted by 1 if in_k[0], else unshifted.
  - Stage i (i≥1) loads data_{i-1} shifted by 2^i if k_{i-1}[i], else unshifted.
  - k and rot propagate unchanged with the data.
- Shift rule:
  - rot=0: result = (x << s) truncated to WIDTH, LSBs zero.
  - rot=1: result = (x << s) | (x >> (WIDTH-s)), all within WIDTH bits.
- Per-stage ready chain, purely combinational:
  - ready_{SHW-1} = !valid_{SHW-1} || out_ready.
  - ready_i = !valid_i || ready_{i+1}.
  - in_ready = ready_0.
- Stage update at the clock edge when ready_i=1:
  - valid_i <= upstream valid (in_valid for i=0, valid_{i-1} otherwise).
  - Data/k/rot load only when the upstream is valid.
  - When ready_i=0, the stage holds all its fields.
- Handshakes:
  - Input transfer occurs on an edge where in_valid && in_ready.
  - Output transfer occurs on an edge where out_valid && out_ready.
  - out_data and out_valid must stay stable while out_valid=1 && out_ready=0.
- Latency and throughput:
  - With no stall, an operand accepted at edge E appears with out_valid=1 after edge E+SHW-1, i.e. SHW register stages.
  - Throughput is one result per cycle.
- Capacity and bubbles:
  - Capacity is SHW transactions.
  - in_ready falls only when every stage is valid and out_ready=0.
  - Bubbles collapse: a stalled output lets empty upstream stages keep filling.
- Boundary conditions:
  - k=0: pass-through for both modes.
  - k=WIDTH-1, logical: only A[0] survives, at the MSB.
  - Rotate by any k is lossless.
  - Simultaneous output drain and input accept on a full pipe: all stages advance, no loss, no duplication.
- Reset mid-operation: in-flight transactions are discarded, with no partial output. After rst_n rises, the first accepted operand sees the normal latency.
- in_data, in_k and in_rot are don't-care when in_valid=0. Values are never sampled from a non-valid cycle.
- No combinational path from in_valid or in_data to the outputs. The only combinational path is out_ready to in_ready.

Test Plan:
- Logical, single op: in_data=8'h01, in_k=3, in_rot=0, out_ready=1 -> out_data=8'h08, with out_valid high after the 3rd edge including the acceptance edge.
- Boundaries, logical: 8'h81 k=7 -> 8'h80; 8'hA5 k=0 -> 8'hA5; 8'hFF k=4 -> 8'hF0.
- Rotate: 8'h81 k=1 -> 8'h03; 8'hB4 k=4 -> 8'h4B; 8'h81 k=7 -> 8'hC0.
- Streaming: 8 back-to-back operands (8'h01, k=0..7, logical) with out_ready=1 -> 8'h01, 02, 04, 08, 10, 20, 40, 80 on 8 consecutive cycles, in_ready held at 1.
- Backpressure: out_ready=0 while in_valid=1 continuously -> exactly 3 operands accepted, then in_ready=0 and out_data stable. Raise out_ready -> 3 results in order on consecutive cycles, in_ready=1 again on the same edge as the first drain.
- Async reset: assert rst_n=0 mid-cycle with 2 operands in flight -> out_valid=0, busy=0, out_data=0 before the next edge. After release, a new op 8'h03 k=2 logical -> 8'h0C with normal latency; no stale result emerges.
